scope_trigger_capture: RTL
==========================

Name: scope_trigger_capture

Overview:
- Sits directly downstream of the ADC front-end (`scope`) block.
- Consumes the 8-bit sample stream plus a per-sample strobe and detects a level-crossing trigger.
- Captures a pre/post-trigger window into an on-chip circular buffer (iCE40 BRAM).
- Replays the window oldest-first over a valid/ready readout port, for a later UART/display stage.

Parameters:
- DATA_W, 8: sample width in bits.
- DEPTH_LOG2, 9: log2 of the capture depth; DEPTH = 512 samples.
- AUTO_TIMEOUT, 65535: samples to wait in ARMED before a forced trigger. Used only with the optional feature.

Ports:
- iCLK  in  1  system clock, 100 MHz.
- iRSTn  in  1  asynchronous active-low reset.
- iSample  in  DATA_W  ADC sample, qualified by iSampleValid.
- iSampleValid  in  1  one-cycle strobe per new ADC sample.
- iArm  in  1  pulse: start a capture (accepted only in IDLE or DONE).
- iAbort  in  1  pulse: return to IDLE from any state.
- iTrigLevel  in  DATA_W  trigger threshold.
- iTrigFalling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger.
- iPreCount  in  DEPTH_LOG2  requested pre-trigger samples; sampled on arm.
- oBusy  out  1  high in PREFILL, ARMED, POST.
- oTriggered  out  1  one-cycle pulse when the trigger sample is written.
- oDone  out  1  high in DONE.
- oRdData  out  DATA_W  readout sample.
- oRdValid  out  1  oRdData valid.
- iRdReady  in  1  consumer accepts oRdData.
- oRdLast  out  1  marks the final (DEPTH-th) readout word.

Behaviour:
- Reset values: all outputs 0; state IDLE; write pointer, counters and latched PRE all 0.
- States:
  - IDLE: waits for iArm.
  - PREFILL: writes samples until PRE samples are stored.
  - ARMED: waits for the trigger condition.
  - POST: writes POST = DEPTH-1-PRE further samples.
  - DONE: replays the buffer.
- Transitions:
  - IDLE -> PREFILL on iArm. Latch PRE = min(iPreCount, DEPTH-1).
  - PREFILL -> ARMED when PRE samples have been written; immediately if PRE = 0.
  - ARMED -> POST on trigger. The trigger sample is written at address T and oTriggered pulses in the same cycle as that write.
  - POST -> DONE after POST further samples. If POST = 0, go to DONE directly from the trigger write.
  - DONE -> PREFILL on iArm (re-arm aborts any readout in progress).
  - Any state -> IDLE on iAbort. iAbort wins over iArm when both occur in the same cycle.
- Writes happen only on iSampleValid in PREFILL, ARMED and POST.
- The write pointer wraps modulo DEPTH and is not reset on re-arm.
- Trigger is evaluated only on iSampleValid in ARMED, against the previous valid sample prev:
  - rising: prev < iTrigLevel and iSample >= iTrigLevel;
  - falling: prev > iTrigLevel and iSample <= iTrigLevel.
- prev updates on every iSampleValid in all states. On reset and on entry to PREFILL, prev is forced so that no false trigger occurs: prev = all-ones for rising, all-zeros for falling.
- Comparisons are unsigned.
- Readout:
  - Entering DONE sets the read address to (T - PRE) mod DEPTH and the read count to 0.
  - BRAM read latency is 1 cycle; oRdValid first asserts 2 cycles after entering DONE.
  - The word holds while oRdValid & ~iRdReady.
  - The address advances on oRdValid & iRdReady.
  - Exactly DEPTH words are delivered; oRdLast is high on word DEPTH-1.
  - After the last handshake, oRdValid stays 0 until the next arm.
- iArm while oBusy is ignored.
- Asynchronous reset mid-capture returns to IDLE. BRAM contents are undefined and never read before the next completed capture.

Optional Feature:
- Macro: SCOPE_AUTO_TRIG_EN.
- Defined: a sample counter runs in ARMED. When AUTO_TIMEOUT valid samples pass without a trigger, the current sample is treated as the trigger sample and oAutoTrig (1-bit output, reset 0) pulses together with oTriggered.
- Undefined: no counter and no oAutoTrig port; ARMED waits indefinitely.

Decomposition:
- Package scope_pkg:
  - state enum {IDLE, PREFILL, ARMED, POST, DONE};
  - DATA_W and DEPTH_LOG2 defaults;
  - trigger edge constants.
- One natural sub-module: scope_capture_ram, a simple dual-port BRAM with one write port and a registered read port, inferable as iCE40 SB_RAM40_4K.

Test Plan:
- Ramp 0..255 repeating, level 0x80, rising, PRE = 100, one sample every 4 clocks -> oTriggered on sample 0x80. Readout: 512 words, word 100 = 0x80, word 0 = 0x1C, oRdLast on word 511.
- Same ramp, iTrigFalling = 1, level 0x40 -> trigger only at the 0xFF->0x00 wrap, never on the upward ramp (first sample <= 0x40 after a larger prev is 0x00). Readout word PRE = 0x00.
- PRE = 0 and PRE = 511 (iPreCount = 511) -> word 0 / word 511 respectively equal the trigger sample. PRE = 511 enters DONE directly from the trigger write.
- iRdReady toggled randomly 50% -> no word dropped or duplicated; oRdData is stable while stalled; exactly 512 handshakes.
- iAbort in POST, then iArm, then iArm while busy -> IDLE, a clean new capture, and the second arm ignored. iRSTn low mid-POST -> all outputs 0 asynchronously.
- SCOPE_AUTO_TRIG_EN, AUTO_TIMEOUT = 1000, constant input 0x10 -> oAutoTrig and oTriggered pulse on the 1000th armed sample. The full readout is all 0x10.

Source files
------------

// File: rtl/scope_pkg.sv
// Shared types and defaults for the scope trigger/capture block.
// State encoding, default geometry and trigger edge selectors.
package scope_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int DEPTH_LOG2_DEF = 9;

    localparam logic EDGE_RISING  = 1'b0;
    localparam logic EDGE_FALLING = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } state_t;

    function automatic logic is_capturing(input state_t s);
        return (s == ST_PREFILL) || (s == ST_ARMED) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/scope_trigger_capture_if.sv
// Readout stream of the capture buffer: valid/ready with a last-word marker.
// The capture block drives it through the master modport.
interface scope_trigger_capture_if
    import scope_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] oRdData;
    logic              oRdValid;
    logic              iRdReady;
    logic              oRdLast;

    modport master (output oRdData, output oRdValid, output oRdLast, input iRdReady);
    modport slave  (input oRdData, input oRdValid, input oRdLast, output iRdReady);
endinterface

// File: rtl/scope_capture_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
// Shaped so the iCE40 flow maps it onto SB_RAM40_4K blocks.
module scope_capture_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // NOTE: no reset here -- block RAM cannot be cleared in one cycle, and
    // non-blocking writes keep the read of the old word race-free.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/scope_trigger_capture.sv
// Level-crossing trigger with pre/post window capture and oldest-first replay.
// Optional forced trigger after a timeout in ARMED: define SCOPE_AUTO_TRIG_EN.
module scope_trigger_capture
    import scope_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
`ifdef SCOPE_AUTO_TRIG_EN
    , parameter int AUTO_TIMEOUT = 65535
`endif
) (
    input  logic                  iCLK,
    input  logic                  iRSTn,
    input  logic [DATA_W-1:0]     iSample,
    input  logic                  iSampleValid,
    input  logic                  iArm,
    input  logic                  iAbort,
    input  logic [DATA_W-1:0]     iTrigLevel,
    input  logic                  iTrigFalling,
    input  logic [DEPTH_LOG2-1:0] iPreCount,
    output logic                  oBusy,
    output logic                  oTriggered,
    output logic                  oDone,
`ifdef SCOPE_AUTO_TRIG_EN
    output logic                  oAutoTrig,
`endif
    scope_trigger_capture_if.master rd
);

    typedef logic [DEPTH_LOG2-1:0] addr_t;
    localparam addr_t ADDR_MAX = addr_t'((1 << DEPTH_LOG2) - 1);

    state_t            state_q, state_d;
    addr_t             wr_ptr_q, cnt_q, pre_q, trig_addr_q;
    logic [DATA_W-1:0] prev_q;
    logic              wr_en, trig_fire, enter_prefill, enter_done;
    logic              rise_hit, fall_hit, level_hit, auto_hit;

    assign rise_hit  = (prev_q < iTrigLevel) && (iSample >= iTrigLevel);
    assign fall_hit  = (prev_q > iTrigLevel) && (iSample <= iTrigLevel);
    assign level_hit = (iTrigFalling == EDGE_FALLING) ? fall_hit : rise_hit;

`ifdef SCOPE_AUTO_TRIG_EN
    localparam int AUTO_W = $clog2(AUTO_TIMEOUT + 1);
    logic [AUTO_W-1:0] auto_cnt_q;

    assign auto_hit = (auto_cnt_q == AUTO_W'(AUTO_TIMEOUT - 1));

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            auto_cnt_q <= '0;
        end else if (state_q != ST_ARMED) begin
            auto_cnt_q <= '0;
        end else if (iSampleValid) begin
            auto_cnt_q <= auto_cnt_q + 1'b1;
        end
    end

    assign oAutoTrig = trig_fire && !level_hit;
`else
    assign auto_hit = 1'b0;
`endif

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        trig_fire = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (iArm) state_d = ST_PREFILL;
            end
            ST_PREFILL: begin
                if (pre_q == '0) begin
                    state_d = ST_ARMED;
                end else if (iSampleValid) begin
                    wr_en = 1'b1;
                    if (cnt_q == pre_q - 1'b1) state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (iSampleValid) begin
                    wr_en = 1'b1;
                    if (level_hit || auto_hit) begin
                        trig_fire = 1'b1;
                        state_d   = (pre_q == ADDR_MAX) ? ST_DONE : ST_POST;
                    end
                end
            end
            ST_POST: begin
                if (iSampleValid) begin
                    wr_en = 1'b1;
                    if (cnt_q == ADDR_MAX - pre_q - 1'b1) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (iArm) state_d = ST_PREFILL;
            end
            default: state_d = ST_IDLE;
        endcase
        if (iAbort) begin
            state_d   = ST_IDLE;
            wr_en     = 1'b0;
            trig_fire = 1'b0;
        end
    end

    assign enter_prefill = (state_d == ST_PREFILL) && (state_q != ST_PREFILL);
    assign enter_done    = (state_d == ST_DONE) && (state_q != ST_DONE);

    assign oBusy      = is_capturing(state_q);
    assign oDone      = (state_q == ST_DONE);
    assign oTriggered = trig_fire;

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            pre_q       <= '0;
            trig_addr_q <= '0;
            prev_q      <= '1;
        end else begin
            state_q <= state_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (enter_prefill || trig_fire) begin
                cnt_q <= '0;
            end else if (wr_en && state_q != ST_ARMED) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // iPreCount is DEPTH_LOG2 wide, so it can never exceed DEPTH-1.
            if (enter_prefill) pre_q <= iPreCount;
            if (trig_fire) trig_addr_q <= wr_ptr_q;
            // The seeded prev value can never satisfy the selected crossing.
            if (enter_prefill) begin
                prev_q <= (iTrigFalling == EDGE_RISING) ? '1 : '0;
            end else if (iSampleValid) begin
                prev_q <= iSample;
            end
        end
    end

    addr_t             rd_ptr_q, rd_cnt_q;
    logic              rd_start_q, rd_issue_q, rd_valid_q;
    logic              rd_hs, rd_last, ram_re;
    logic [DATA_W-1:0] ram_q;

    assign rd_hs   = rd_valid_q && rd.iRdReady;
    assign rd_last = (rd_cnt_q == ADDR_MAX);
    // Fetch the next word in the same cycle as the handshake: no bubbles.
    assign ram_re  = rd_issue_q || (rd_hs && !rd_last);

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            rd_ptr_q   <= '0;
            rd_cnt_q   <= '0;
            rd_start_q <= 1'b0;
            rd_issue_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else if (enter_done) begin
            rd_ptr_q   <= (trig_fire ? wr_ptr_q : trig_addr_q) - pre_q;
            rd_cnt_q   <= '0;
            rd_start_q <= 1'b1;
            rd_issue_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else if (state_q != ST_DONE || state_d != ST_DONE) begin
            rd_start_q <= 1'b0;
            rd_issue_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_start_q <= 1'b0;
            rd_issue_q <= rd_start_q;
            if (ram_re) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (rd_issue_q) begin
                rd_valid_q <= 1'b1;
            end else if (rd_hs) begin
                if (rd_last) rd_valid_q <= 1'b0;
                else         rd_cnt_q   <= rd_cnt_q + 1'b1;
            end
        end
    end

    scope_capture_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (iCLK),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (iSample),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (ram_q)
    );

    assign rd.oRdValid = rd_valid_q;
    assign rd.oRdData  = rd_valid_q ? ram_q : '0;
    assign rd.oRdLast  = rd_valid_q && rd_last;

endmodule
